// File: rtl/lpc_host_xfer.sv
// LPC host cycle engine: I/O or memory cycles for 1..2^LEN_W bytes, one LPC cycle per byte.
// Optional abort sequence on SYNC timeout: define LPC_HOST_ABORT_EN.
module lpc_host_xfer #(
    parameter int unsigned LEN_W        = 3,
    parameter int unsigned SYNC_TIMEOUT = 8,
    parameter int unsigned LWAIT_MAX    = 255
) (
    input  logic             lclk,
    input  logic             lreset,
    input  logic [3:0]       lad_in,
    output logic [3:0]       lad_out,
    output logic             lad_oe,
    output logic             lframe,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_io,
    input  logic             req_inc,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wr_data,
    output logic             wr_take,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             err
);

    localparam int unsigned SC_W = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_CTDIR, S_ADDR, S_WDATA,
        S_TAR0, S_SYNC, S_RDATA, S_TAR1, S_ABORT
    } state_t;

    state_t            state, nxt_state;
    logic [2:0]        cnt, nxt_cnt;
    logic [SC_W-1:0]   scnt, nxt_scnt;
    logic [7:0]        lcnt, nxt_lcnt;
    logic [31:0]       addr, nxt_addr;
    logic [LEN_W-1:0]  len, nxt_len;
    logic              wr_q, nxt_wr, io_q, nxt_io, inc_q, nxt_inc;
    logic              err_flag, nxt_eflag;
    logic [3:0]        lo_nib, nxt_lo;
    logic [7:0]        nxt_rd_data;
    logic              nxt_rd_valid, nxt_done, nxt_err, nxt_wr_take;
    logic              nxt_lframe, nxt_oe, nxt_req_ready;
    logic [3:0]        nxt_lad;
    logic              fail;
    logic [2:0]        addr_last, nib_sel;

    always_comb begin
        nxt_state     = state;
        nxt_scnt      = scnt;
        nxt_lcnt      = lcnt;
        nxt_addr      = addr;
        nxt_len       = len;
        nxt_wr        = wr_q;
        nxt_io        = io_q;
        nxt_inc       = inc_q;
        nxt_eflag     = err_flag;
        nxt_lo        = lo_nib;
        nxt_rd_data   = rd_data;
        nxt_rd_valid  = 1'b0;
        nxt_done      = 1'b0;
        nxt_err       = 1'b0;
        nxt_wr_take   = 1'b0;
        nxt_lframe    = 1'b1;
        nxt_oe        = 1'b0;
        nxt_lad       = '0;
        nxt_cnt       = '0;
        nxt_req_ready = 1'b0;
        fail          = 1'b0;
        addr_last     = io_q ? 3'd3 : 3'd7;
        nib_sel       = '0;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    nxt_addr  = req_addr;
                    nxt_len   = req_len;
                    nxt_wr    = req_write;
                    nxt_io    = req_io;
                    nxt_inc   = req_inc;
                    nxt_eflag = 1'b0;
                    nxt_state = S_START;
                end
            end
            S_START: nxt_state = S_CTDIR;
            S_CTDIR: nxt_state = S_ADDR;
            S_ADDR: begin
                if (cnt == addr_last) nxt_state = wr_q ? S_WDATA : S_TAR0;
            end
            S_WDATA: begin
                if (cnt == 3'd1) nxt_state = S_TAR0;
            end
            S_TAR0: begin
                if (cnt == 3'd1) begin
                    nxt_state = S_SYNC;
                    nxt_scnt  = '0;
                    nxt_lcnt  = '0;
                end
            end
            S_SYNC: begin
                case (lad_in)
                    4'b0000, 4'b1010: begin
                        if (lad_in == 4'b1010) nxt_eflag = 1'b1;
                        nxt_state = wr_q ? S_TAR1 : S_RDATA;
                    end
                    4'b0110: begin
                        if (lcnt == 8'(LWAIT_MAX - 1)) fail = 1'b1;
                        else nxt_lcnt = lcnt + 8'd1;
                    end
                    default: begin
                        if (scnt == SC_W'(SYNC_TIMEOUT - 1)) fail = 1'b1;
                        else nxt_scnt = scnt + SC_W'(1);
                    end
                endcase
            end
            S_RDATA: begin
                if (cnt == 3'd0) begin
                    nxt_lo = lad_in;
                end else begin
                    nxt_rd_data  = {lad_in, lo_nib};
                    nxt_rd_valid = 1'b1;
                    nxt_state    = S_TAR1;
                end
            end
            S_TAR1: begin
                if (cnt == 3'd1) begin
                    if (len != '0) begin
                        nxt_len = len - LEN_W'(1);
                        if (inc_q) begin
                            if (io_q) nxt_addr = {addr[31:16], addr[15:0] + 16'd1};
                            else      nxt_addr = addr + 32'd1;
                        end
                        nxt_state = S_START;
                    end else begin
                        nxt_state = S_IDLE;
                        nxt_done  = 1'b1;
                        nxt_err   = err_flag;
                    end
                end
            end
`ifdef LPC_HOST_ABORT_EN
            S_ABORT: begin
                // done/err are registered, so they are raised entering the final (lframe=1) cycle
                if (cnt == 3'd3) begin
                    nxt_done = 1'b1;
                    nxt_err  = 1'b1;
                end
                if (cnt == 3'd4) nxt_state = S_IDLE;
            end
`endif
            default: nxt_state = S_IDLE;
        endcase

        if (fail) begin
`ifdef LPC_HOST_ABORT_EN
            nxt_state = S_ABORT;
`else
            nxt_state = S_IDLE;
            nxt_done  = 1'b1;
            nxt_err   = 1'b1;
`endif
        end

        nxt_cnt       = (nxt_state == state) ? cnt + 3'd1 : 3'd0;
        nxt_req_ready = (nxt_state == S_IDLE) && !nxt_done;
        nib_sel       = addr_last - nxt_cnt;

        // Pad outputs are decoded from the upcoming state so they register in step with it
        case (nxt_state)
            S_START: begin
                nxt_lframe = 1'b0;
                nxt_oe     = 1'b1;
            end
            S_CTDIR: begin
                nxt_oe  = 1'b1;
                nxt_lad = {1'b0, ~io_q, wr_q, 1'b0};
            end
            S_ADDR: begin
                nxt_oe  = 1'b1;
                nxt_lad = addr[{nib_sel, 2'b00} +: 4];
            end
            S_WDATA: begin
                nxt_oe      = 1'b1;
                nxt_lad     = (nxt_cnt == 3'd0) ? wr_data[3:0] : wr_data[7:4];
                nxt_wr_take = (nxt_cnt == 3'd1);
            end
            S_TAR0: begin
                if (nxt_cnt == 3'd0) begin
                    nxt_oe  = 1'b1;
                    nxt_lad = 4'b1111;
                end
            end
`ifdef LPC_HOST_ABORT_EN
            S_ABORT: begin
                if (nxt_cnt != 3'd4) begin
                    nxt_lframe = 1'b0;
                    nxt_oe     = 1'b1;
                    nxt_lad    = 4'b1111;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge lclk) begin
        if (lreset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            scnt      <= '0;
            lcnt      <= '0;
            addr      <= '0;
            len       <= '0;
            wr_q      <= 1'b0;
            io_q      <= 1'b0;
            inc_q     <= 1'b0;
            err_flag  <= 1'b0;
            lo_nib    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_take   <= 1'b0;
            lframe    <= 1'b1;
            lad_oe    <= 1'b0;
            lad_out   <= '0;
            req_ready <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            scnt      <= nxt_scnt;
            lcnt      <= nxt_lcnt;
            addr      <= nxt_addr;
            len       <= nxt_len;
            wr_q      <= nxt_wr;
            io_q      <= nxt_io;
            inc_q     <= nxt_inc;
            err_flag  <= nxt_eflag;
            lo_nib    <= nxt_lo;
            rd_data   <= nxt_rd_data;
            rd_valid  <= nxt_rd_valid;
            done      <= nxt_done;
            err       <= nxt_err;
            wr_take   <= nxt_wr_take;
            lframe    <= nxt_lframe;
            lad_oe    <= nxt_oe;
            lad_out   <= nxt_lad;
            req_ready <= nxt_req_ready;
        end
    end

endmodule
